// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-to-decode handshake: {pc, instruction} with valid/ready.
interface imem_fetch_ctrl_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;
  logic [31:0] pc;

  modport master (output valid, output data, output pc, input ready);
  modport slave  (input valid, input data, input pc, output ready);
endinterface

// File: rtl/imem_fetch_ctrl_fifo.sv
// Small skid FIFO of fetch entries; flush dominates push and pop.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output fetch_entry_t rdata,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, buffers fetched words and
// hands {pc, instruction} to decode; absorbs redirects and halt requests.
module imem_fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic [31:0]               mem_addr,
  input  logic [31:0]               mem_rdata,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  input  logic                      halt,
  imem_fetch_ctrl_if.master         inst,
  output logic                      halted
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push, pop, flush;
  logic         full, empty;
  fetch_entry_t head;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    flush   = 1'b0;
    push    = 1'b0;
    pop     = !empty && inst.ready;

    case (state_q)
      IDLE:    state_d = halt ? HALT : RUN;
      RUN:     if (halt)  state_d = HALT;
      HALT:    if (!halt) state_d = RUN;
      default: state_d = IDLE;
    endcase

    // Redirect wins over everything but leaves the state untouched.
    if (redirect_valid && state_q != IDLE) begin
      flush   = 1'b1;
      pop     = 1'b0;
      state_d = state_q;
      pc_d    = redirect_pc & ~32'h3;
    end else if (state_q == RUN && !halt && (!full || pop)) begin
      push = 1'b1;
      pc_d = pc_q + PC_STEP;
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata ('{pc: pc_q, instr: mem_rdata}),
    .rdata (head),
    .full  (full),
    .empty (empty)
  );

  assign mem_addr   = pc_q;
  assign inst.valid = !empty;
  assign inst.data  = head.instr;
  assign inst.pc    = head.pc;
  assign halted     = (state_q == HALT) && empty;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Randomized and directed bench for imem_fetch_ctrl against a queue-based model.
module tb_imem_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int unsigned DEPTH  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        halt = 1'b0;
  logic        halted;

  imem_fetch_ctrl_if inst_if ();

  imem_fetch_ctrl #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst           (inst_if),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0062E233;
      32'h4:   return 32'h00B67433;
      32'h8:   return 32'h00B60433;
      default: return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  assign mem_rdata = imem(mem_addr);

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: fetch PC, ordered buffer contents, started/stopped flags.
  logic [31:0] m_pc;
  logic [63:0] m_q[$];
  bit          m_started;
  bit          m_stopped;
  logic [63:0] dut_log[$];

  task automatic model_reset();
    m_pc = RST_PC;
    m_q.delete();
    m_started = 0;
    m_stopped = 0;
  endtask

  task automatic model_update(input bit rdy, input bit hlt, input bit rv, input logic [31:0] rpc);
    bit do_pop, do_fetch;
    if (!m_started) begin
      m_started = 1;
      m_stopped = hlt;
    end else if (rv) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
    end else begin
      do_pop   = (m_q.size() > 0) && rdy;
      do_fetch = !m_stopped && !hlt && ((m_q.size() < DEPTH) || do_pop);
      if (do_pop) void'(m_q.pop_front());
      if (do_fetch) begin
        m_q.push_back({m_pc, imem(m_pc)});
        m_pc = m_pc + 32'd4;
      end
      m_stopped = hlt;
    end
  endtask

  task automatic compare_outputs();
    check_eq("mem_addr", mem_addr, m_pc);
    check_eq("inst_valid", 32'(inst_if.valid), 32'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check_eq("inst_pc", inst_if.pc, m_q[0][63:32]);
      check_eq("inst_data", inst_if.data, m_q[0][31:0]);
    end
    check_eq("halted", 32'(halted), 32'(m_started && m_stopped && m_q.size() == 0));
  endtask

  task automatic step(input bit rdy, input bit hlt, input bit rv, input logic [31:0] rpc);
    @(negedge clk);
    inst_if.ready  = rdy;
    halt           = hlt;
    redirect_valid = rv;
    redirect_pc    = rpc;
    compare_outputs();
    if (inst_if.valid && rdy && !rv) dut_log.push_back({inst_if.pc, inst_if.data});
    model_update(rdy, hlt, rv, rpc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_valid", 32'(inst_if.valid), 32'h0);
    check_eq("rst_addr", mem_addr, RST_PC);
    check_eq("rst_halted", 32'(halted), 32'h0);
    check_eq("rst_inst_pc", inst_if.pc, 32'h0);
    check_eq("rst_inst_data", inst_if.data, 32'h0);
    model_reset();
    dut_log.delete();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [31:0] held;
    inst_if.ready = 1'b0;
    model_reset();
    #1;
    check_eq("por_valid", 32'(inst_if.valid), 32'h0);
    check_eq("por_addr", mem_addr, RST_PC);
    check_eq("por_halted", 32'(halted), 32'h0);
    @(posedge clk);
    #2 rst = 1'b0;

    // In-order stream with ready held high
    repeat (6) step(1, 0, 0, '0);
    check_eq("seq_n", dut_log.size(), 4);
    check_eq("seq0_pc", dut_log[0][63:32], 32'h0);
    check_eq("seq0_data", dut_log[0][31:0], 32'h0062E233);
    check_eq("seq1_pc", dut_log[1][63:32], 32'h4);
    check_eq("seq1_data", dut_log[1][31:0], 32'h00B67433);
    check_eq("seq2_pc", dut_log[2][63:32], 32'h8);
    check_eq("seq2_data", dut_log[2][31:0], 32'h00B60433);

    // Backpressure: FIFO fills, fetch address stalls at 0x8
    do_reset();
    repeat (7) step(0, 0, 0, '0);
    @(negedge clk);
    check_eq("stall_addr", mem_addr, 32'h8);
    repeat (5) step(1, 0, 0, '0);
    check_eq("bp0_pc", dut_log[0][63:32], 32'h0);
    check_eq("bp1_pc", dut_log[1][63:32], 32'h4);
    check_eq("bp2_pc", dut_log[2][63:32], 32'h8);

    // Redirect while full flushes stale entries
    do_reset();
    repeat (5) step(0, 0, 0, '0);
    step(1, 0, 1, 32'h0000_0043);
    dut_log.delete();
    repeat (4) step(1, 0, 0, '0);
    check_eq("redir_first_pc", dut_log[0][63:32], 32'h40);
    check_eq("redir_next_pc", dut_log[1][63:32], 32'h44);

    // PC wraps past the top of the address space
    step(1, 0, 1, 32'hFFFF_FFF8);
    dut_log.delete();
    repeat (4) step(1, 0, 0, '0);
    check_eq("wrap0", dut_log[0][63:32], 32'hFFFF_FFF8);
    check_eq("wrap1", dut_log[1][63:32], 32'hFFFF_FFFC);
    check_eq("wrap2", dut_log[2][63:32], 32'h0000_0000);

    // Halt with two entries buffered: drain, halted, address frozen
    do_reset();
    repeat (5) step(0, 0, 0, '0);
    held = m_pc;
    repeat (4) step(1, 1, 0, '0);
    @(negedge clk);
    check_eq("halt_done", 32'(halted), 32'h1);
    check_eq("halt_addr", mem_addr, held);
    check_eq("halt_drained", dut_log.size(), 2);
    dut_log.delete();
    repeat (4) step(1, 0, 0, '0);
    check_eq("resume_pc", dut_log[0][63:32], held);

    // Mid-stream reset, then first output must be RESET_PC
    do_reset();
    repeat (4) step(1, 0, 0, '0);
    check_eq("post_rst_pc", dut_log[0][63:32], RST_PC);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit rdy, hlt, rv;
      logic [31:0] rpc;
      if ($urandom_range(0, 199) == 0) do_reset();
      rdy = ($urandom_range(0, 3) != 0);
      hlt = ($urandom_range(0, 9) == 0);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 1) != 0) ? $urandom() : (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)));
      step(rdy, hlt, rv, rpc);
    end
    @(negedge clk);
    compare_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch sequencer for the instruction memory's single combinational read port. It owns the fetch PC, drives the memory address, captures read data into a small skid FIFO, and presents {pc, instruction} to decode with a valid/ready handshake. It also absorbs redirects (branch/jump/trap) and a halt request. It sits between the instruction memory and the decode stage.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset; bits [1:0] must be 0.
- DEPTH, 2: FIFO entries; power of two, 2..8.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_addr  out  32  fetch address to the instruction memory; equals the fetch PC.
- mem_rdata  in  32  instruction word; combinational from mem_addr, valid in the same cycle.
- redirect_valid  in  1  one-cycle request to restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch PC; bits [1:0] are forced to 0 internally.
- halt  in  1  level; while high, no new fetches are issued.
- inst_valid  out  1  FIFO head is valid.
- inst_ready  in  1  decode accepts the head this cycle.
- inst_data  out  32  instruction at the FIFO head.
- inst_pc  out  32  PC of the instruction at the FIFO head.
- halted  out  1  state is HALT and the FIFO is empty.

## Operation
- States:
  - IDLE: entered at reset; no fetch.
  - RUN: fetching.
  - HALT: fetch stopped.
- Transitions:
  - IDLE -> RUN on the first clock after rst falls (or -> HALT if halt=1).
  - RUN -> HALT when halt=1.
  - HALT -> RUN when halt=0.
- Fetch (RUN, halt=0, no redirect): the fetch is performed when the FIFO has space or a pop happens this cycle.
  - Push {pc, mem_rdata}.
  - pc <= pc + 4, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Fetch is not performed when the FIFO is full and inst_ready=0. In that case pc holds and mem_addr is unchanged.
- Pop: occurs when inst_valid && inst_ready. Push and pop in the same cycle are legal, including when the FIFO is full.
- Redirect has the highest priority and is accepted in any state except IDLE:
  - The FIFO is flushed, including any entry that would have been pushed or popped that cycle.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - No push that cycle.
  - The state is unchanged (a redirect during HALT only updates pc).
- halt only blocks pushes. Existing entries still drain to decode.
- mem_rdata is sampled only on push cycles. Its value is ignored otherwise.

## Timing
- Reset values:
  - state=IDLE, pc=RESET_PC, mem_addr=RESET_PC.
  - FIFO empty, inst_valid=0.
  - inst_data=0, inst_pc=0.
  - halted=0.
- Fetch-to-output latency is 1 cycle: an instruction pushed at edge N appears as inst_valid at N+1 when the FIFO was empty.
- Steady state: with inst_ready held high, throughput is one instruction per cycle.
- Redirect at edge N:
  - inst_valid=0 after N.
  - mem_addr=redirect_pc after N.
  - The first redirected instruction is valid after N+1.
- inst_data and inst_pc are stable while inst_valid=1 and inst_ready=0.
- halted rises the cycle after the last entry pops while in HALT.
- rst mid-operation: all state returns immediately to the reset values, asynchronously. In-flight FIFO contents are discarded.

## Structure
- Shared package fetch_pkg holds:
  - the state encoding (IDLE, RUN, HALT);
  - PC_STEP = 4;
  - the default RESET_PC;
  - the fetch entry type {pc[31:0], instr[31:0]}.
- One sub-module, fetch_fifo:
  - DEPTH x 64-bit entries;
  - push, pop and flush inputs, with flush dominant;
  - full and empty outputs;
  - count width $clog2(DEPTH)+1.
- The top level holds the FSM, the PC register and the push/pop/flush decode.

## Test plan
- Memory model holds [0]=0x0062E233, [1]=0x00B67433, [2]=0x00B60433. Release reset with inst_ready=1 -> outputs in order (pc 0, 0x0062E233), (pc 4, 0x00B67433), (pc 8, 0x00B60433) on consecutive cycles.
- Hold inst_ready=0 for 5 cycles after the first fetch -> the FIFO fills to 2 and mem_addr stalls at 0x8. Release ready -> no entry is lost or duplicated.
- Assert redirect_valid with redirect_pc=0x0000_0043 while the FIFO is full -> the FIFO is flushed, the next inst_pc is 0x40, and no stale 0x4/0x8 entries appear.
- Start at pc=0xFFFF_FFF8 with ready=1 -> inst_pc sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Raise halt with 2 entries buffered -> both entries drain, halted=1 a cycle later, and mem_addr is constant. Drop halt -> fetch resumes at the held pc.
- Pulse rst mid-stream -> the next edge shows inst_valid=0, mem_addr=RESET_PC and halted=0. The first valid output after reset is at pc RESET_PC.
